// File: rtl/pool_pkg.sv
// pool_pkg
// Shared definitions for the max-pooling window sequencer and its PE
// interface: PE control encodings, per-isize max identities and the
// sequencer state type.
package pool_pkg;

  // PE operation select: SET loads the element, COMPARE keeps the running max.
  localparam logic POOL_CTRL_SET     = 1'b0;
  localparam logic POOL_CTRL_COMPARE = 1'b1;

  // Most-negative value per lane, so a COMPARE with it never changes the max.
  localparam logic [15:0] POOL_ID_8X2 = 16'h8080;
  localparam logic [15:0] POOL_ID_16  = 16'h8000;

  // S_FIRST: next accepted element opens a window. S_ACC: inside a window.
  typedef enum logic {
    S_FIRST = 1'b0,
    S_ACC   = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_win_cnt.sv
// pool_win_cnt
// Pooling-window element counter. Latches the window length on the element
// that opens a window and flags whether the element offered now would be the
// window's last one.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   adv          an element is accepted this cycle
//   cfg_win_len  requested window length (0 -> 1, above MAX_WIN_LEN -> MAX_WIN_LEN)
//   state        S_FIRST / S_ACC
//   last         an element accepted now closes the window
module pool_win_cnt
  import pool_pkg::*;
#(
  parameter int MAX_WIN_LEN = 9,
  parameter int CNT_W       = $clog2(MAX_WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [CNT_W-1:0] cfg_win_len,
  output pool_state_e      state,
  output logic             last
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] eff_len;

  // Lengths outside 1..MAX_WIN_LEN are clamped so the counter always wraps.
  always_comb begin
    eff_len = cfg_win_len;
    if (cfg_win_len == '0)
      eff_len = CNT_W'(1);
    else if (cfg_win_len > CNT_W'(MAX_WIN_LEN))
      eff_len = CNT_W'(MAX_WIN_LEN);
  end

  // In S_FIRST the length is not latched yet, so look at the live config.
  assign last = (state == S_FIRST) ? (eff_len == CNT_W'(1))
                                   : (cnt == win_len - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FIRST;
      cnt     <= '0;
      win_len <= CNT_W'(1);
    end else if (adv) begin
      if (state == S_FIRST)
        win_len <= eff_len;
      if (last) begin
        state <= S_FIRST;
        cnt   <= '0;
      end else begin
        state <= S_ACC;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pool_win_seq.sv
// pool_win_seq
// Window sequencer feeding one max-pooling PE lane. Streams elements from the
// line buffer to the PE with SET on a window's first element and COMPARE on
// the rest, then captures the PE's registered max into a one-entry output
// register with a valid/ready handshake.
//
// Optional build macro: POOL_RELU_EN -- clamp each negative signed lane of
// the captured result to zero. Undefined: result is passed through unchanged.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_win_len       elements per window, sampled at window start
//   cfg_isize         0 = two signed 8-bit lanes, 1 = one signed 16-bit word
//   in_valid/in_ready/in_data     element stream from the line buffer
//   pool_ctrl         0 = SET, 1 = COMPARE, to PE
//   pool_set_isize    lane format, to PE
//   pool_idata        element (or max identity during gaps), to PE
//   pool_odata        PE registered max
//   out_valid/out_ready/out_data  pooled result stream
module pool_win_seq
  import pool_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MAX_WIN_LEN = 9,
  parameter int CNT_W       = $clog2(MAX_WIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     cfg_win_len,
  input  logic                 cfg_isize,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 pool_ctrl,
  output logic                 pool_set_isize,
  output logic [WORD_SIZE-1:0] pool_idata,
  input  logic [WORD_SIZE-1:0] pool_odata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data
);

  pool_state_e          state;
  logic                 last;
  logic                 accept;
  logic                 win_start;
  logic                 cap_pend;
  logic                 isize_q;
  logic [WORD_SIZE-1:0] cap_word;

`ifdef POOL_RELU_EN
  function automatic logic [WORD_SIZE-1:0] relu_clamp(
    input logic [WORD_SIZE-1:0] d,
    input logic                 isize
  );
    logic signed [WORD_SIZE-1:0]   w;
    logic signed [WORD_SIZE/2-1:0] hi;
    logic signed [WORD_SIZE/2-1:0] lo;
    w  = d;
    hi = d[WORD_SIZE-1:WORD_SIZE/2];
    lo = d[WORD_SIZE/2-1:0];
    if (isize) begin
      relu_clamp = (w < 0) ? '0 : d;
    end else begin
      relu_clamp = {(hi < 0) ? {(WORD_SIZE/2){1'b0}} : d[WORD_SIZE-1:WORD_SIZE/2],
                    (lo < 0) ? {(WORD_SIZE/2){1'b0}} : d[WORD_SIZE/2-1:0]};
    end
  endfunction

  assign cap_word = relu_clamp(pool_odata, isize_q);
`else
  assign cap_word = pool_odata;
`endif

  pool_win_cnt #(
    .MAX_WIN_LEN (MAX_WIN_LEN),
    .CNT_W       (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .adv         (accept),
    .cfg_win_len (cfg_win_len),
    .state       (state),
    .last        (last)
  );

  // Only a window-closing element needs room downstream: it must not collide
  // with a capture still pending or a result that cannot leave this cycle.
  assign in_ready  = !rst && (!last || (!cap_pend && (!out_valid || out_ready)));
  assign accept    = in_valid && in_ready;
  assign win_start = accept && (state == S_FIRST);

  // The PE registers these on the same edge as the accept. With no element,
  // COMPARE against the lane identity so the running max is held.
  always_comb begin
    pool_ctrl      = POOL_CTRL_COMPARE;
    pool_set_isize = isize_q;
    pool_idata     = isize_q ? WORD_SIZE'(POOL_ID_16) : WORD_SIZE'(POOL_ID_8X2);
    if (accept) begin
      pool_idata = in_data;
      if (win_start) begin
        pool_ctrl      = POOL_CTRL_SET;
        pool_set_isize = cfg_isize;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isize_q  <= 1'b1;
      cap_pend <= 1'b0;
    end else begin
      if (win_start)
        isize_q <= cfg_isize;
      cap_pend <= accept && last;
    end
  end

  // Capture stage: the PE max is valid the cycle after the last element.
  // isize_q still describes the finished window here, since a new window can
  // only relatch it at the end of this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cap_pend) begin
      out_valid <= 1'b1;
      out_data  <= cap_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_win_seq.sv
module tb_pool_win_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_win_len;
  logic        cfg_isize;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        pool_ctrl;
  logic        pool_set_isize;
  logic [15:0] pool_idata;
  logic [15:0] pool_odata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  pool_win_seq #(.WORD_SIZE(16), .MAX_WIN_LEN(9), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_win_len    (cfg_win_len),
    .cfg_isize      (cfg_isize),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .pool_ctrl      (pool_ctrl),
    .pool_set_isize (pool_set_isize),
    .pool_idata     (pool_idata),
    .pool_odata     (pool_odata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word_max(input logic [15:0] a, input logic [15:0] b,
                                           input logic isize);
    logic [7:0] h;
    logic [7:0] l;
    if (isize)
      return ($signed(a) > $signed(b)) ? a : b;
    h = ($signed(a[15:8]) > $signed(b[15:8])) ? a[15:8] : b[15:8];
    l = ($signed(a[7:0])  > $signed(b[7:0]))  ? a[7:0]  : b[7:0];
    return {h, l};
  endfunction

  function automatic logic [15:0] finish_word(input logic [15:0] d, input logic isize);
`ifdef POOL_RELU_EN
    logic [15:0] r;
    r = d;
    if (isize) begin
      if (d[15]) r = 16'h0000;
    end else begin
      if (d[15]) r[15:8] = 8'h00;
      if (d[7])  r[7:0]  = 8'h00;
    end
    return r;
`else
    if (isize) return d;
    return d;
`endif
  endfunction

  // Behavioural PE: registered max, SET loads, COMPARE keeps the max.
  logic [15:0] pe_max = 16'h0000;
  always @(posedge clk) begin
    if (pool_ctrl == 1'b0) pe_max <= pool_idata;
    else                   pe_max <= word_max(pe_max, pool_idata, pool_set_isize);
  end
  assign pool_odata = pe_max;

  // Scoreboard
  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int          len_m;
  int          idx_m;
  logic        isize_m;
  logic [15:0] acc_m;

  task automatic begin_window(input logic isize, input int len);
    cfg_isize   = isize;
    cfg_win_len = 4'(len);
    isize_m     = isize;
    len_m       = (len == 0) ? 1 : len;
    idx_m       = 0;
  endtask

  task automatic wait_accept();
    int n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "accept wait expired");
      end
    end
    check_eq("pool_ctrl", {31'd0, pool_ctrl}, (idx_m == 0) ? 32'd0 : 32'd1);
    check_eq("pool_idata", {16'd0, pool_idata}, {16'd0, in_data});
    check_eq("pool_isize", {31'd0, pool_set_isize}, {31'd0, isize_m});
    acc_m = (idx_m == 0) ? in_data : word_max(acc_m, in_data, isize_m);
    idx_m++;
    if (idx_m == len_m) begin
      e.data = finish_word(acc_m, isize_m);
      e.cyc  = cyc;
      exp_q.push_back(e);
      idx_m = 0;
    end
    @(posedge clk);
    #1;
    // Config changes inside a window must be ignored.
    if (idx_m == 1 && len_m > 1) begin
      cfg_win_len = 4'd2;
      cfg_isize   = ~isize_m;
    end
  endtask

  task automatic send_elem(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("gap_ctrl", {31'd0, pool_ctrl}, 32'd1);
      check_eq("gap_idata", {16'd0, pool_idata}, isize_m ? 32'h8000 : 32'h8080);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_left", exp_q.size(), 32'd0);
    #1;
  endtask

  // Output monitor: latency on each new result, data on each handshake.
  logic prev_vld = 1'b0;
  logic prev_hs  = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && (!prev_vld || prev_hs)) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 32'd1, 32'd0);
        else check_eq("latency", cyc - exp_q[0].cyc, 32'd2);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check_eq("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        void'(exp_q.pop_front());
      end
    end
    prev_vld = out_valid;
    prev_hs  = out_valid && out_ready;
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b1;
    cfg_win_len = 4'd1;
    cfg_isize   = 1'b1;
    isize_m     = 1'b1;
    len_m       = 1;
    idx_m       = 0;
    acc_m       = 16'h0000;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
    check_eq("rst_pool_ctrl", {31'd0, pool_ctrl}, 32'd1);
    check_eq("rst_pool_idata", {16'd0, pool_idata}, 32'h8000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 16-bit 2x2, back-to-back
    begin_window(1'b1, 4);
    send_elem(16'h0005); send_elem(16'hFFFE); send_elem(16'h0007); send_elem(16'h0003);
    // two 8-bit lanes
    begin_window(1'b0, 4);
    send_elem(16'h05FE); send_elem(16'h8001); send_elem(16'h7F80); send_elem(16'h0000);
    // gap inside a window
    begin_window(1'b1, 4);
    send_elem(16'h0005); send_elem(16'hFFFE);
    idle(3);
    send_elem(16'h0007); send_elem(16'h0003);
    drain();

    // backpressure over two windows
    out_ready = 1'b0;
    begin_window(1'b1, 4);
    send_elem(16'h0001); send_elem(16'h0002); send_elem(16'h0004); send_elem(16'h0003);
    begin_window(1'b1, 4);
    send_elem(16'h0010); send_elem(16'h0020); send_elem(16'h0030);
    in_valid = 1'b1;
    in_data  = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_data", {16'd0, out_data}, 32'h0004);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();

    // reset mid-window
    begin_window(1'b1, 4);
    send_elem(16'h0009); send_elem(16'h0002);
    rst = 1'b1;
    #1;
    check_eq("midrst_ctrl", {31'd0, pool_ctrl}, 32'd1);
    check_eq("midrst_idata", {16'd0, pool_idata}, 32'h8000);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    begin_window(1'b1, 4);
    send_elem(16'h0001); send_elem(16'h0001); send_elem(16'h0001); send_elem(16'h0001);

    // all-negative 16-bit window
    begin_window(1'b1, 4);
    send_elem(16'hFFF0); send_elem(16'hFFF8); send_elem(16'hFF00); send_elem(16'h8000);

    // single-element windows, including length 0
    begin_window(1'b1, 1);
    send_elem(16'h1234);
    begin_window(1'b0, 0);
    send_elem(16'h80FF);
    begin_window(1'b1, 1);
    send_elem(16'h7FFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_win_seq.md
# pool_win_seq

Window sequencer that drives a max-pooling PE from a streaming feature-map buffer. It accepts one packed word per cycle over a valid/ready handshake and counts elements of each pooling window. It issues SET on the first element of a window and COMPARE on the rest, then captures the PE's registered max into a one-entry output register. It sits between the input line buffer and the PE array, one instance per PE lane.

## Interface
- WORD_SIZE, 16, packed data width (one 16-bit word or two 8-bit lanes)
- MAX_WIN_LEN, 9, maximum elements per window (3x3)
- CNT_W, $clog2(MAX_WIN_LEN+1), window counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_win_len  in  CNT_W  elements per window (4 = 2x2, 9 = 3x3); 0 treated as 1; sampled at window start
- cfg_isize  in  1  0 = two signed 8-bit lanes, 1 = one signed 16-bit word; sampled at window start
- in_valid  in  1  input element valid
- in_ready  out  1  sequencer accepts element this cycle
- in_data  in  WORD_SIZE  input element
- pool_ctrl  out  1  0 = SET, 1 = COMPARE, to PE
- pool_set_isize  out  1  latched cfg_isize, to PE
- pool_idata  out  WORD_SIZE  element to PE
- pool_odata  in  WORD_SIZE  PE registered max
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WORD_SIZE  pooled result

## Operation
- States: S_FIRST (cnt = 0, next accept starts a window) and S_ACC (cnt in 1..win_len-1). The window length and isize are latched on the S_FIRST accept.
- The handshake is accept = in_valid && in_ready. The pool_* outputs are combinational from the accept and the state, and the PE registers them on the same edge.
- Accept in S_FIRST: pool_ctrl = SET and pool_idata = in_data. cnt becomes 1, or stays 0 with a capture if win_len = 1.
- Accept in S_ACC: pool_ctrl = COMPARE and pool_idata = in_data. cnt increments. On the last element (cnt = win_len-1), cnt returns to 0 and the state returns to S_FIRST.
- No accept: pool_ctrl = COMPARE and pool_idata = the identity (16'h8080 when isize = 0, 16'h8000 when isize = 1). This leaves the PE max unchanged during gaps.
- A last-element accept sets cap_pend. On the next cycle, out_data is loaded from pool_odata, out_valid is set, and cap_pend clears.
- out_valid clears on out_valid && out_ready unless a capture occurs in the same cycle; a capture wins.
- in_ready = 1, except for an element that would be a window's last: that element requires !cap_pend && (!out_valid || out_ready).
- Arithmetic is signed per lane. The sequencer never modifies data except under the macro.

## Timing
- Reset values: out_valid = 0, out_data = 0, state S_FIRST, cnt = 0, cap_pend = 0, latched isize = 1, latched win_len = 1. During reset, pool_ctrl = COMPARE and pool_idata = 16'h8000.
- Latency: last element accepted at cycle t, PE max valid at t+1, out_valid = 1 at t+2.
- Throughput: one element per cycle. No bubbles for win_len ≥ 2 when the consumer is ready. win_len = 1 runs at half rate.
- Reset mid-window discards the partial window and cap_pend. The next accept is a SET.
- cfg changes mid-window are ignored until the next S_FIRST accept.

## Configuration
- POOL_RELU_EN defined: at capture, each signed lane (per latched isize) is clamped to 0 if negative.
- POOL_RELU_EN undefined: out_data equals pool_odata exactly.

## Structure
- Shared package pool_pkg holds:
  - POOL_CTRL_SET = 0 and POOL_CTRL_COMPARE = 1
  - identity constants POOL_ID_8X2 = 16'h8080 and POOL_ID_16 = 16'h8000
  - the state enum {S_FIRST, S_ACC}
- Sub-module pool_win_cnt: the window counter with latched length and a last-element flag. The handshake and capture logic stay in the top.

## Test plan
- isize = 1, win_len = 4, inputs 0x0005, 0xFFFE, 0x0007, 0x0003 back-to-back. Expect pool_ctrl SET,C,C,C; out_data 0x0007; out_valid two cycles after the 4th accept.
- isize = 0, win_len = 4, inputs 0x05FE, 0x8001, 0x7F80, 0x0000. Expect out_data 0x7F01.
- win_len = 4 with in_valid low for 3 cycles after the 2nd element. Expect pool_idata = 0x8000 and pool_ctrl = COMPARE during the gap, and the result is unchanged vs. the gap-free run.
- out_ready held 0 over two consecutive 2x2 windows. Expect in_ready = 0 on the second window's last element until out_ready = 1, and the first result is not overwritten.
- rst pulse after 2 of 4 elements, then a clean window of 0x0001 ×4. Expect out_data 0x0001, and the first post-reset accept is SET.
- isize = 1, inputs 0xFFF0, 0xFFF8, 0xFF00, 0x8000. Expect out_data 0xFFF8 without POOL_RELU_EN and 0x0000 with it.
